// File: rtl/laser_point_feeder.sv
`timescale 1ns/1ps
// laser_point_feeder
// Front-end for the LASER two-circle core. Points arrive on a valid/ready stream and
// are banked into two ping-pong frames of N_PTS entries. A full frame is replayed to
// the core one point per cycle while the core is released from reset; after the core
// signals DONE its circles are captured and offered on a valid/ready result port.
// A new frame is never started while a result is still waiting to be taken.
module laser_point_feeder #(
  parameter int N_PTS = 40,
  parameter int CW    = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CW-1:0]   in_x,
  input  logic [CW-1:0]   in_y,
  output logic            core_rst,
  output logic [CW-1:0]   core_x,
  output logic [CW-1:0]   core_y,
  input  logic            core_done,
  input  logic [4*CW-1:0] core_circ,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [4*CW-1:0] res_circ,
  output logic            busy
);

  localparam int IW = $clog2(N_PTS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PTS - 1);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_WAIT   = 2'd2,
    S_CAPT   = 2'd3
  } state_t;

  // Point storage: two banks, no reset needed since the full flags gate every read.
  logic [CW-1:0] bank_x_r [0:1][0:N_PTS-1];
  logic [CW-1:0] bank_y_r [0:1][0:N_PTS-1];

  logic [1:0]      full_r;
  logic            wr_bank_r;
  logic            rd_bank_r;
  logic [IW-1:0]   wr_idx_r;
  logic [IW-1:0]   rd_idx_r;
  state_t          state_r;

  logic            core_rst_r;
  logic [CW-1:0]   core_x_r;
  logic [CW-1:0]   core_y_r;
  logic            res_valid_r;
  logic [4*CW-1:0] res_circ_r;
  logic            busy_r;

  logic            beat_s;
  logic            fill_s;
  logic            release_s;
  logic [1:0]      set_full_s;
  logic [1:0]      clr_full_s;
  logic [IW-1:0]   rd_next_s;

  // The write bank accepts points until it holds a complete frame.
  assign in_ready = ~full_r[wr_bank_r];

  assign core_rst  = core_rst_r;
  assign core_x    = core_x_r;
  assign core_y    = core_y_r;
  assign res_valid = res_valid_r;
  assign res_circ  = res_circ_r;
  assign busy      = busy_r;

  // Handshake decode and full-flag set/clear requests; fill and release always target
  // different banks, so both may happen in the same cycle.
  always_comb begin
    beat_s     = in_valid & ~full_r[wr_bank_r];
    fill_s     = beat_s && (wr_idx_r == LAST_IDX);
    release_s  = (state_r == S_STREAM) && (rd_idx_r == LAST_IDX);
    rd_next_s  = rd_idx_r + ONE_IDX;
    set_full_s = 2'b00;
    clr_full_s = 2'b00;
    if (fill_s) begin
      set_full_s[wr_bank_r] = 1'b1;
    end else begin
      set_full_s = 2'b00;
    end
    if (release_s) begin
      clr_full_s[rd_bank_r] = 1'b1;
    end else begin
      clr_full_s = 2'b00;
    end
  end

  // Store each accepted point into the current write bank.
  always_ff @(posedge CLK) begin
    if (!RST && beat_s) begin
      bank_x_r[wr_bank_r][wr_idx_r] <= in_x;
      bank_y_r[wr_bank_r][wr_idx_r] <= in_y;
    end
  end

  // Write pointer: advance per beat, switch banks after the last point of a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_idx_r  <= {IW{1'b0}};
      wr_bank_r <= 1'b0;
    end else if (beat_s) begin
      if (wr_idx_r == LAST_IDX) begin
        wr_idx_r  <= {IW{1'b0}};
        wr_bank_r <= ~wr_bank_r;
      end else begin
        wr_idx_r <= wr_idx_r + ONE_IDX;
      end
    end
  end

  // Bank occupancy flags, set by the writer on fill and cleared by the reader on release.
  always_ff @(posedge CLK) begin
    if (RST) begin
      full_r <= 2'b00;
    end else begin
      full_r <= (full_r | set_full_s) & ~clr_full_s;
    end
  end

  // Control FSM: start a frame, replay it, wait for DONE, capture and hold the result.
  // The start test uses the registered res_valid, so a result handshake in the same
  // cycle defers the next start by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= S_IDLE;
      rd_bank_r   <= 1'b0;
      rd_idx_r    <= {IW{1'b0}};
      core_rst_r  <= 1'b1;
      core_x_r    <= {CW{1'b0}};
      core_y_r    <= {CW{1'b0}};
      res_valid_r <= 1'b0;
      res_circ_r  <= {(4*CW){1'b0}};
      busy_r      <= 1'b0;
    end else begin
      if (res_valid_r && res_ready) begin
        res_valid_r <= 1'b0;
      end
      case (state_r)
        S_IDLE: begin
          if (full_r[rd_bank_r] && !res_valid_r) begin
            state_r    <= S_STREAM;
            core_rst_r <= 1'b0;
            core_x_r   <= bank_x_r[rd_bank_r][{IW{1'b0}}];
            core_y_r   <= bank_y_r[rd_bank_r][{IW{1'b0}}];
            rd_idx_r   <= {IW{1'b0}};
            busy_r     <= 1'b1;
          end
        end
        S_STREAM: begin
          // rd_idx_r names the point currently on core_x/core_y.
          if (release_s) begin
            rd_bank_r <= ~rd_bank_r;
            rd_idx_r  <= {IW{1'b0}};
            core_x_r  <= {CW{1'b0}};
            core_y_r  <= {CW{1'b0}};
            state_r   <= S_WAIT;
          end else begin
            core_x_r <= bank_x_r[rd_bank_r][rd_next_s];
            core_y_r <= bank_y_r[rd_bank_r][rd_next_s];
            rd_idx_r <= rd_next_s;
          end
        end
        S_WAIT: begin
          if (core_done) begin
            state_r <= S_CAPT;
          end
        end
        S_CAPT: begin
          res_circ_r  <= core_circ;
          res_valid_r <= 1'b1;
          core_rst_r  <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= S_IDLE;
        end
        default: begin
          state_r    <= S_IDLE;
          core_rst_r <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule
